div_arbiter: RTL
================

# div_arbiter

Shares one serial divider between N_PORTS requesting processes by round-robin arbitration. It sequences the divider's start/calculate/finish handshake and returns each quotient to the requester that owns it. It sits between the compiled C process FSMs, which issue divide requests over stb/ack ports, and a single serial divider instance. Divide-by-zero is bypassed, and a hung divider is caught by a watchdog.

## Interface
- N_PORTS, 4, number of requesters (2..8)
- WIDTH, 16, operand/quotient width, two's complement
- TIMEOUT, 32, maximum cycles in WAIT before error return
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_stb  in  N_PORTS  per-port request strobe; held until matching req_ack
- req_numerator  in  N_PORTS*WIDTH  packed, port i at [i*WIDTH +: WIDTH]
- req_denominator  in  N_PORTS*WIDTH  packed, same layout
- req_ack  out  N_PORTS  one-cycle pulse: operands captured
- res_stb  out  N_PORTS  result valid for port i, held until res_ack[i]
- res_ack  in  N_PORTS  requester accepts result
- res_quotient  out  WIDTH  result for the port whose res_stb is high
- res_dbz  out  1  result is divide-by-zero (quotient 0)
- res_err  out  1  result is watchdog timeout (quotient 0)
- div_stb  out  1  start strobe to the divider
- div_numerator  out  WIDTH  dividend to the divider, stable from grant until div_ack
- div_denominator  out  WIDTH  divisor to the divider, same stability rule
- div_ack  in  1  divider completion pulse; div_quotient valid in the same cycle
- div_quotient  in  WIDTH  divider result

## Operation
- States: IDLE, ISSUE, WAIT, RETURN.
- **IDLE**
  - Select the first port with req_stb high, searching rr_ptr, rr_ptr+1, … modulo N_PORTS.
  - On a hit:
    - latch grant g and both operands into div_numerator/div_denominator;
    - pulse req_ack[g];
    - set rr_ptr = (g+1) mod N_PORTS.
  - If the denominator is 0: go to RETURN with quotient 0 and dbz=1. The divider is not started.
  - Otherwise go to ISSUE.
- **ISSUE**
  - div_stb=1 for exactly one cycle.
  - Clear watchdog counter.
  - Go to WAIT.
- **WAIT**
  - When div_ack=1: capture div_quotient, go to RETURN.
  - Otherwise increment the watchdog.
  - When the watchdog reaches TIMEOUT: go to RETURN with quotient 0 and err=1.
- **RETURN**
  - res_stb[g]=1; res_quotient, res_dbz and res_err are registered and held.
  - When res_ack[g]=1: clear res_stb, dbz and err, go to IDLE.
- Arithmetic: quotient is passed through unmodified.
  - Truncates toward zero, e.g. -7/2 = -3.
  - -2^(WIDTH-1) / -1 returns -2^(WIDTH-1) with no flag.
- Arbitration is fair: with all ports requesting continuously, each port is served once per N_PORTS transactions.
- Only one transaction is in flight. Requests arriving in non-IDLE states wait; req_stb must stay high until req_ack.
- res_ack on a port without res_stb is ignored. A div_ack outside WAIT is ignored.
- A late div_ack after a timeout is ignored. The next ISSUE occurs only after the divider's acknowledge state (guaranteed by the ≥2-cycle RETURN/IDLE gap).

## Timing
- Reset values:
  - state IDLE, rr_ptr 0;
  - req_ack 0, res_stb 0, div_stb 0;
  - res_quotient 0, res_dbz 0, res_err 0;
  - div_numerator 0, div_denominator 0.
- Reset mid-transaction drops the transaction with no result; the divider shares rst and also returns to start.
- Grant and req_ack are seen the cycle after req_stb is sampled in IDLE.
- div_stb is asserted the cycle after grant.
- res_stb is asserted the cycle after div_ack.
- With the 18-cycle serial divider: req_stb sampled at cycle t → req_ack high at t+1 → res_stb high at t+21.
- If res_ack is high the same cycle: IDLE at t+22, next grant at t+23.
- Divide-by-zero: req_ack and res_stb both high at t+1, and res_stb is held until res_ack.
- Outputs are all registered; no combinational path from req_* or res_ack to any output.

## Test plan
- Single port 0, 100/7, res_ack tied high → req_ack[0] at t+1, div_stb once, res_quotient=14 on res_stb[0] at t+21, dbz=err=0.
- Ports 1, 2, 3 request simultaneously from reset (rr_ptr=0) with operands -100/7, 9/3, 5/-2 → served in order 1, 2, 3 with quotients -14, 3, -2; rr_ptr ends at 0.
- Port 2 holds its request continuously while ports 0/1 re-request after each result → grant sequence 0, 1, 2, 0, 1, 2…; no port starved.
- Port 3 issues 55/0 → res_stb[3] with quotient 0 and res_dbz=1; div_stb never asserted.
- Divider model never acks → res_err=1 with quotient 0 after TIMEOUT cycles in WAIT. A later spurious div_ack is ignored; the next request completes normally.
- rst asserted during WAIT, then a new request 32767/-1 → all outputs at reset values the cycle after rst, then the result is -32767 on the granted port.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one serial divider among N_PORTS requesters.
// Bypasses divide-by-zero and returns an error result if the divider hangs.
module div_arbiter #(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_stb,
  input  logic [N_PORTS*WIDTH-1:0]   req_numerator,
  input  logic [N_PORTS*WIDTH-1:0]   req_denominator,
  output logic [N_PORTS-1:0]         req_ack,
  output logic [N_PORTS-1:0]         res_stb,
  input  logic [N_PORTS-1:0]         res_ack,
  output logic signed [WIDTH-1:0]    res_quotient,
  output logic                       res_dbz,
  output logic                       res_err,
  output logic                       div_stb,
  output logic signed [WIDTH-1:0]    div_numerator,
  output logic signed [WIDTH-1:0]    div_denominator,
  input  logic                       div_ack,
  input  logic signed [WIDTH-1:0]    div_quotient
);

  localparam int PW = $clog2(N_PORTS);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RET} state_t;

  state_t                   state, state_nx;
  logic [PW-1:0]            rr_ptr;
  logic [PW-1:0]            gnt_p1;
  logic [TW-1:0]            wd;

  logic signed [WIDTH-1:0]  num_a [N_PORTS];
  logic signed [WIDTH-1:0]  den_a [N_PORTS];

  logic                     sel_hit_p0;
  logic [PW-1:0]            sel_idx_p0;
  logic [PW-1:0]            rr_nx_p0;
  logic signed [WIDTH-1:0]  sel_num_p0;
  logic signed [WIDTH-1:0]  sel_den_p0;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign num_a[i] = req_numerator[i*WIDTH +: WIDTH];
    assign den_a[i] = req_denominator[i*WIDTH +: WIDTH];
  end

  // Stage p0: round-robin search starting at rr_ptr
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    sel_hit_p0 = 1'b0;
    sel_idx_p0 = '0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_PORTS)) sum = sum - (PW+1)'(N_PORTS);
      cand = sum[PW-1:0];
      if (!sel_hit_p0 && req_stb[cand]) begin
        sel_hit_p0 = 1'b1;
        sel_idx_p0 = cand;
      end
    end
    sel_num_p0 = num_a[sel_idx_p0];
    sel_den_p0 = den_a[sel_idx_p0];
    rr_nx_p0   = (sel_idx_p0 == PW'(N_PORTS-1)) ? '0 : sel_idx_p0 + 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (sel_hit_p0) state_nx = (sel_den_p0 == '0) ? S_RET : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (div_ack || wd == TW'(TIMEOUT-1)) state_nx = S_RET;
      S_RET:   if (res_ack[gnt_p1]) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p1: registered grant, divider handshake and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      gnt_p1          <= '0;
      wd              <= '0;
      req_ack         <= '0;
      res_stb         <= '0;
      div_stb         <= 1'b0;
      res_quotient    <= '0;
      res_dbz         <= 1'b0;
      res_err         <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
    end else begin
      state   <= state_nx;
      req_ack <= '0;
      div_stb <= 1'b0;
      case (state)
        S_IDLE: if (sel_hit_p0) begin
          gnt_p1              <= sel_idx_p0;
          rr_ptr              <= rr_nx_p0;
          req_ack[sel_idx_p0] <= 1'b1;
          div_numerator       <= sel_num_p0;
          div_denominator     <= sel_den_p0;
          if (sel_den_p0 == '0) begin
            res_stb[sel_idx_p0] <= 1'b1;
            res_quotient        <= '0;
            res_dbz             <= 1'b1;
          end
        end
        S_ISSUE: begin
          div_stb <= 1'b1;
          wd      <= '0;
        end
        S_WAIT: begin
          if (div_ack) begin
            res_quotient    <= div_quotient;
            res_stb[gnt_p1] <= 1'b1;
          end else if (wd == TW'(TIMEOUT-1)) begin
            res_quotient    <= '0;
            res_err         <= 1'b1;
            res_stb[gnt_p1] <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RET: if (res_ack[gnt_p1]) begin
          res_stb <= '0;
          res_dbz <= 1'b0;
          res_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
